// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPressDb,
        StHeld,
        StRelDb
    } state_e;

    typedef enum logic [1:0] {
        FrameNone,
        FrameSingle,
        FrameMulti
    } frame_e;

    localparam logic [3:0] ColReset = 4'b1110;

endpackage

// File: rtl/scan_tick.sv
// Free-running divider: one-cycle tick every SCAN_DIV clocks.
module scan_tick #(
    parameter int unsigned SCAN_DIV = 25000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row sampling, frame debounce, hex digit accumulator.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 25000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  row_i,
    output logic [3:0]  col_o,
    output logic        key_valid_o,
    output logic [3:0]  key_code_o,
    output logic [15:0] num_o
);

    localparam logic [3:0] DebLimit = 4'(DEBOUNCE);

    logic        tick;
    logic [3:0]  sync1_q, sync2_q;
    logic [1:0]  col_idx_q, col_idx_d;
    logic [3:0]  col_q, col_d;
    logic [15:0] snap_q, snap_d;
    logic        frame_done;
    logic [4:0]  pop;
    logic [3:0]  frame_code;
    frame_e      frame_class;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  cand_q, cand_d;
    logic        key_valid_q, key_valid_d;
    logic [3:0]  key_code_q, key_code_d;
    logic [15:0] num_q, num_d;
    logic        accept;
    logic [3:0]  acc_code;

    scan_tick #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan_tick (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .tick_o(tick)
    );

    // snap_d overlays the column being sampled now, so frame_done sees the whole frame.
    always_comb begin
        col_idx_d = col_idx_q;
        col_d     = col_q;
        snap_d    = snap_q;
        if (tick) begin
            for (int r = 0; r < 4; r++) begin
                snap_d[{2'(r), col_idx_q}] = ~sync2_q[r];
            end
            col_idx_d = col_idx_q + 2'd1;
            col_d     = {col_q[2:0], col_q[3]};
        end
    end

    assign frame_done = tick && (col_idx_q == 2'd3);

    always_comb begin
        pop        = '0;
        frame_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (snap_d[i]) begin
                pop        = pop + 5'd1;
                frame_code = 4'(i);
            end
        end
        if (pop == 5'd0) begin
            frame_class = FrameNone;
        end else if (pop == 5'd1) begin
            frame_class = FrameSingle;
        end else begin
            frame_class = FrameMulti;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        accept      = 1'b0;
        acc_code    = cand_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        num_d       = num_q;
        if (frame_done) begin
            unique case (state_q)
                StIdle: begin
                    if (frame_class == FrameSingle) begin
                        cand_d = frame_code;
                        if (DebLimit == 4'd1) begin
                            state_d  = StHeld;
                            cnt_d    = '0;
                            accept   = 1'b1;
                            acc_code = frame_code;
                        end else begin
                            state_d = StPressDb;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                StPressDb: begin
                    if (frame_class == FrameSingle && frame_code == cand_q) begin
                        if (cnt_q + 4'd1 == DebLimit) begin
                            state_d = StHeld;
                            cnt_d   = '0;
                            accept  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (frame_class == FrameSingle) begin
                        cand_d = frame_code;
                        cnt_d  = 4'd1;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
                StHeld: begin
                    // No rollover: any pressed key keeps us here until a clean release.
                    if (frame_class == FrameNone) begin
                        if (DebLimit == 4'd1) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else begin
                            state_d = StRelDb;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                StRelDb: begin
                    if (frame_class == FrameNone) begin
                        if (cnt_q + 4'd1 == DebLimit) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = StHeld;
                        cnt_d   = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        if (accept) begin
            key_valid_d = 1'b1;
            key_code_d  = acc_code;
            num_d       = {num_q[11:0], acc_code};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q     <= 4'b1111;
            sync2_q     <= 4'b1111;
            col_idx_q   <= '0;
            col_q       <= ColReset;
            snap_q      <= '0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            num_q       <= '0;
        end else begin
            sync1_q     <= row_i;
            sync2_q     <= sync1_q;
            col_idx_q   <= col_idx_d;
            col_q       <= col_d;
            snap_q      <= snap_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            num_q       <= num_d;
        end
    end

    assign col_o       = col_q;
    assign key_valid_o = key_valid_q;
    assign key_code_o  = key_code_q;
    assign num_o       = num_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: keypad pin model, frame-level reference model, per-cycle compare.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEBOUNCE = 2;
    localparam int FRAME = 4 * SCAN_DIV;

    logic        clk;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] num;
    logic [15:0] keys;

    int n_run;
    int n_fail;

    // Reference model state: frame-level press/release tracker.
    int          k;
    bit          held;
    int          run;
    logic [3:0]  cand;
    logic [15:0] m_num;
    logic [3:0]  m_code;
    logic [15:0] fmask;
    int          n_pulse;
    int          last_pk;

    keypad_scanner #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .row_i      (row),
        .col_o      (col),
        .key_valid_o(key_valid),
        .key_code_o (key_code),
        .num_o      (num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pressed key (r,c) shorts row r to column c.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[4*r+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at k=%0d: got %0h, want %0h", name, k, act, exp);
        end
    endtask

    task automatic model_frame(input logic [15:0] m, output bit acc);
        int n;
        int code;
        n    = $countones(m);
        code = 0;
        acc  = 0;
        for (int i = 0; i < 16; i++) if (m[i]) code = i;
        if (!held) begin
            if (n == 1) begin
                if (run > 0 && code == int'(cand)) run++;
                else begin
                    cand = 4'(code);
                    run  = 1;
                end
                if (run >= DEBOUNCE) begin
                    held   = 1;
                    run    = 0;
                    acc    = 1;
                    m_code = cand;
                    m_num  = {m_num[11:0], cand};
                end
            end else begin
                run = 0;
            end
        end else begin
            if (n == 0) begin
                run++;
                if (run >= DEBOUNCE) begin
                    held = 0;
                    run  = 0;
                end
            end else begin
                run = 0;
            end
        end
    endtask

    // One clock: sample reset at the edge, compare all outputs on the falling edge.
    task automatic cycle();
        bit         r;
        bit         acc;
        logic [3:0] ec;
        @(posedge clk);
        r = rst;
        @(negedge clk);
        acc = 0;
        if (r) begin
            k = 0; held = 0; run = 0; cand = 0; m_num = 0; m_code = 0;
            check("rst_col", 32'(col), 32'h0000000E);
            check("rst_num", 32'(num), 32'h0);
            check("rst_valid", 32'(key_valid), 32'h0);
            check("rst_code", 32'(key_code), 32'h0);
        end else begin
            k++;
            if (k % FRAME == FRAME / 2) fmask = keys;
            if (k % FRAME == 0) model_frame(fmask, acc);
            ec = ~(4'b0001 << ((k / SCAN_DIV) % 4));
            check("col", 32'(col), 32'(ec));
            check("key_valid", 32'(key_valid), 32'(acc));
            check("key_code", 32'(key_code), 32'(m_code));
            check("num", 32'(num), 32'(m_num));
            if (key_valid === 1'b1) begin
                n_pulse++;
                last_pk = k;
            end
        end
    endtask

    task automatic frames(input logic [15:0] m, input int n);
        keys = m;
        repeat (n * FRAME) cycle();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) cycle();
        rst = 1'b0;
    endtask

    initial begin
        int          p0;
        int          hold;
        logic [15:0] m;
        logic [15:0] prev;
        n_run = 0; n_fail = 0; n_pulse = 0; last_pk = -1;
        k = 0; held = 0; run = 0; cand = 0; m_num = 0; m_code = 0; fmask = 0;
        keys = 16'h0;
        rst  = 1'b1;

        // Reset, then a single key 6 (row1/col2).
        do_reset(3);
        p0 = n_pulse;
        frames(16'h0040, 3);
        frames(16'h0000, 3);
        check("t2_pulses", n_pulse - p0, 1);
        check("t2_latency", last_pk, 2 * FRAME);
        check("t2_code", 32'(key_code), 32'h6);
        check("t2_num", 32'(num), 32'h0006);

        // Multi-digit entry.
        for (int d = 1; d <= 4; d++) begin
            frames(16'(1 << d), 3);
            frames(16'h0000, 3);
        end
        check("t3_num1234", 32'(num), 32'h1234);
        frames(16'h8000, 3);
        frames(16'h0000, 3);
        check("t3_num234F", 32'(num), 32'h234F);

        // Bounce on key 9.
        do_reset(2);
        p0 = n_pulse;
        frames(16'h0200, 1);
        frames(16'h0000, 1);
        frames(16'h0200, 3);
        frames(16'h0000, 3);
        check("t4_pulses", n_pulse - p0, 1);
        check("t4_latency", last_pk, 4 * FRAME);
        check("t4_num", 32'(num), 32'h0009);

        // Two-key chord, long hold, and key swap while held.
        do_reset(2);
        p0 = n_pulse;
        frames(16'h0021, 4);
        check("t5_chord", n_pulse - p0, 0);
        frames(16'h0000, 2);
        frames(16'h0080, 10);
        check("t5_hold", n_pulse - p0, 1);
        frames(16'h0180, 2);
        frames(16'h0100, 3);
        frames(16'h0000, 2);
        check("t5_swap", n_pulse - p0, 1);
        check("t5_num", 32'(num), 32'h0007);
        frames(16'h0100, 3);
        frames(16'h0000, 2);
        check("t5_num78", 32'(num), 32'h0078);

        // Reset in the middle of debouncing key A.
        do_reset(2);
        p0 = n_pulse;
        frames(16'h0400, 1);
        keys = 16'h0400;
        repeat (7) cycle();
        do_reset(2);
        check("t6_nopulse", n_pulse - p0, 0);
        check("t6_num0", 32'(num), 32'h0000);
        frames(16'h0400, 3);
        frames(16'h0000, 2);
        check("t6_num", 32'(num), 32'h000A);
        check("t6_pulses", n_pulse - p0, 1);

        // Randomised frames, held for 1..3 frames each.
        do_reset(2);
        prev = 16'h0;
        for (int i = 0; i < 50; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: m = 16'h0;
                3, 4, 5, 6: m = 16'(1 << $urandom_range(0, 15));
                7: m = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
                default: m = prev;
            endcase
            hold = int'($urandom_range(1, 3));
            frames(m, hold);
            prev = m;
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
